// File: rtl/imem_responder.sv
// Instruction-memory responder: pipelined word fetches with branch flush,
// plus a load port guarded by a SERVE/DRAIN/LOAD mode FSM.
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [31:0] proc2Imem_addr,
  input  logic        flush,
  output logic [31:0] Imem2proc_data,
  output logic        Imem2proc_valid,
  output logic [31:0] Imem2proc_addr,
  output logic        Imem2proc_err,
  output logic        imem_busy,
  input  logic        load_en,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Stages that still feed the output; the output stage itself counts as delivered.
  localparam logic [LATENCY-1:0] FEED_MASK = {LATENCY{1'b1}} >> 1;

  typedef enum logic [1:0] {SERVE, DRAIN, LOAD} state_t;

  state_t state;
  state_t next_state;
  logic   busy_next;
  logic   ready_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic               req_valid;
  logic [31:0]        req_addr;
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_err;
  logic [31:0]        pipe_data [LATENCY];
  logic [31:0]        pipe_addr [LATENCY];

  logic        accept;
  logic        req_in_range;
  logic [31:0] rd_data;
  logic        load_hit;
  logic        pipe_empty;
  logic        unused_bits;

  function automatic logic in_range(input logic [31:0] a);
    return {2'b00, a[31:2]} < 32'(DEPTH_WORDS);
  endfunction

  assign accept       = fetch_en && (state == SERVE) && !load_en;
  assign req_in_range = in_range(req_addr);
  assign rd_data      = req_in_range ? mem[req_addr[AW+1:2]] : NOP_WORD;
  assign load_hit     = (state == LOAD) && load_we && in_range(load_addr);
  assign pipe_empty   = !req_valid && ((pipe_valid & FEED_MASK) == '0);
  assign unused_bits  = ^{proc2Imem_addr[1:0], load_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SERVE;
      imem_busy  <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      state      <= next_state;
      imem_busy  <= busy_next;
      load_ready <= ready_next;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      SERVE: if (load_en) next_state = DRAIN;
      DRAIN: begin
        if (!load_en)       next_state = SERVE;
        else if (pipe_empty) next_state = LOAD;
      end
      LOAD:  if (!load_en) next_state = SERVE;
      default: next_state = SERVE;
    endcase
  end

  always_comb begin
    busy_next  = (next_state != SERVE);
    ready_next = (next_state == LOAD);
  end

  // Flush kills everything already sampled but lets a same-cycle fetch through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid  <= 1'b0;
      req_addr   <= '0;
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
        pipe_addr[i] <= '0;
      end
    end else begin
      req_valid <= accept;
      if (accept) req_addr <= {proc2Imem_addr[31:2], 2'b00};
      pipe_valid[0] <= req_valid && !flush;
      pipe_data[0]  <= rd_data;
      pipe_addr[0]  <= req_addr;
      pipe_err[0]   <= !req_in_range;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1] && !flush;
        pipe_data[i]  <= pipe_data[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_hit) mem[load_addr[AW+1:2]] <= load_data;
  end

  assign Imem2proc_valid = pipe_valid[LATENCY-1];
  assign Imem2proc_data  = pipe_data[LATENCY-1];
  assign Imem2proc_addr  = pipe_addr[LATENCY-1];
  assign Imem2proc_err   = pipe_err[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (defaults: 1024 words, latency 2).
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] proc2Imem_addr;
  logic        flush;
  logic [31:0] Imem2proc_data;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_addr;
  logic        Imem2proc_err;
  logic        imem_busy;
  logic        load_en;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_responder dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .proc2Imem_addr(proc2Imem_addr),
    .flush(flush),
    .Imem2proc_data(Imem2proc_data),
    .Imem2proc_valid(Imem2proc_valid),
    .Imem2proc_addr(Imem2proc_addr),
    .Imem2proc_err(Imem2proc_err),
    .imem_busy(imem_busy),
    .load_en(load_en),
    .load_we(load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .load_ready(load_ready)
  );

  function automatic logic [31:0] exp_word(input int i);
    if (i == 0) return 32'h00500093;
    if (i == 1) return 32'h00100113;
    return 32'h10000000 + 32'(i) * 32'h0101;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkResponse(input string tag, input logic exp_valid, input logic [31:0] exp_addr,
                               input logic [31:0] exp_data, input logic exp_err);
    checkOutput({tag, "_valid"}, 32'(Imem2proc_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput({tag, "_data"}, Imem2proc_data, exp_data);
      checkOutput({tag, "_addr"}, Imem2proc_addr, exp_addr);
      checkOutput({tag, "_err"}, 32'(Imem2proc_err), 32'(exp_err));
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that consumes them.
  task automatic applyStimulus(input logic fe, input logic [31:0] fa, input logic fl, input logic le,
                               input logic we, input logic [31:0] la, input logic [31:0] ld);
    fetch_en       = fe;
    proc2Imem_addr = fa;
    flush          = fl;
    load_en        = le;
    load_we        = we;
    load_addr      = la;
    load_data      = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic le);
    applyStimulus(1'b0, 32'h0, 1'b0, le, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    fetch_en = 1'b0; proc2Imem_addr = '0; flush = 1'b0;
    load_en = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(Imem2proc_valid), 32'h0);
    checkOutput("rst_data",  Imem2proc_data, 32'h0);
    checkOutput("rst_addr",  Imem2proc_addr, 32'h0);
    checkOutput("rst_err",   32'(Imem2proc_err), 32'h0);
    checkOutput("rst_busy",  32'(imem_busy), 32'h0);
    checkOutput("rst_ready", 32'(load_ready), 32'h0);
    rst = 1'b1;

    // Enter load mode with an empty pipeline and write the program image.
    idle(1'b1);
    checkOutput("enter_busy",  32'(imem_busy), 32'h1);
    checkOutput("enter_ready", 32'(load_ready), 32'h0);
    idle(1'b1);
    checkOutput("load_ready", 32'(load_ready), 32'h1);
    for (int i = 0; i <= 16; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'(4 * i), exp_word(i));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00001000, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hCAFEF00D);
    idle(1'b0);
    checkOutput("exit_busy",  32'(imem_busy), 32'h0);
    checkOutput("exit_ready", 32'(load_ready), 32'h0);

    // Load then fetch: two back-to-back fetches, latency 2.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("lf_early0", 32'(Imem2proc_valid), 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("lf_early1", 32'(Imem2proc_valid), 32'h0);
    idle(1'b0);
    checkResponse("lf_w0", 1'b1, 32'h0, 32'h00500093, 1'b0);
    idle(1'b0);
    checkResponse("lf_w1", 1'b1, 32'h4, 32'h00100113, 1'b0);
    idle(1'b0);
    checkOutput("lf_after", 32'(Imem2proc_valid), 32'h0);

    // Back-to-back streaming of 16 words.
    for (int j = 0; j < 18; j++) begin
      applyStimulus(j < 16, 32'(4 * j), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (j >= 2)
        checkResponse($sformatf("stream%0d", j - 2), 1'b1, 32'(4 * (j - 2)), exp_word(j - 2), 1'b0);
      else
        checkOutput("stream_lead", 32'(Imem2proc_valid), 32'h0);
    end
    idle(1'b0);
    checkOutput("stream_end", 32'(Imem2proc_valid), 32'h0);

    // Flush with a branch-target fetch in the same cycle.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("flush_kill0", 32'(Imem2proc_valid), 32'h0);
    idle(1'b0);
    checkOutput("flush_kill1", 32'(Imem2proc_valid), 32'h0);
    idle(1'b0);
    checkResponse("flush_tgt", 1'b1, 32'h40, exp_word(16), 1'b0);
    idle(1'b0);
    checkOutput("flush_end", 32'(Imem2proc_valid), 32'h0);

    // Out-of-range fetches return the NOP with err set.
    applyStimulus(1'b1, 32'h00001000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b0);
    checkResponse("oor_1000", 1'b1, 32'h00001000, 32'h00000013, 1'b1);
    idle(1'b0);
    checkResponse("oor_wrap", 1'b1, 32'hFFFFFFFC, 32'h00000013, 1'b1);
    idle(1'b0);
    checkOutput("oor_end", 32'(Imem2proc_valid), 32'h0);

    // Drain: load_en with two fetches in flight while fetch_en stays high.
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkResponse("drain_w2", 1'b1, 32'h8, exp_word(2), 1'b0);
    checkOutput("drain_busy", 32'(imem_busy), 32'h1);
    checkOutput("drain_ready0", 32'(load_ready), 32'h0);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkResponse("drain_w3", 1'b1, 32'hC, exp_word(3), 1'b0);
    checkOutput("drain_ready1", 32'(load_ready), 32'h0);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("drain_done_valid", 32'(Imem2proc_valid), 32'h0);
    checkOutput("drain_done_ready", 32'(load_ready), 32'h1);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("load_hold_valid", 32'(Imem2proc_valid), 32'h0);
    idle(1'b0);
    checkOutput("drain_exit_busy", 32'(imem_busy), 32'h0);
    for (int j = 0; j < 3; j++) begin
      idle(1'b0);
      checkOutput($sformatf("drain_nostray%0d", j), 32'(Imem2proc_valid), 32'h0);
    end

    // Asynchronous reset between edges with fetches in flight.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ar_pre_valid", 32'(Imem2proc_valid), 32'h1);
    fetch_en = 1'b0;
    #3 rst = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(Imem2proc_valid), 32'h0);
    checkOutput("ar_data",  Imem2proc_data, 32'h0);
    checkOutput("ar_busy",  32'(imem_busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      idle(1'b0);
      checkOutput($sformatf("ar_gone%0d", j), 32'(Imem2proc_valid), 32'h0);
    end

    // The array survives reset.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    checkResponse("post_rst_w0", 1'b1, 32'h0, 32'h00500093, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
